// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   uart_rx_state_e : receiver FSM states
//   UART_DATA_BITS  : payload bits per frame (8N1 framing)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    ERR_WAIT = 3'd4
  } uart_rx_state_e;

  localparam int unsigned UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset; both flops load RST_VAL
//   i_d    : asynchronous input
//   o_q    : synchronized output, two cycles behind i_d
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver feeding the ICCM program loader.
//   clk_i       : system clock
//   rst_ni      : asynchronous active-low reset
//   rx_i        : asynchronous serial line, idle high
//   rx_dv_o     : one-cycle strobe, rx_byte_o holds a freshly received byte
//   rx_byte_o   : last correctly framed byte (LSB received first), held
//   frame_err_o : one-cycle strobe, stop bit was sampled low
//   busy_o      : receiver is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       rx_dv_o,
  output logic [7:0] rx_byte_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned       HALF     = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(HALF);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam int unsigned       IDX_W    = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  logic                      w_rx_s;
  uart_rx_state_e            r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [IDX_W-1:0]          r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [7:0]                r_byte;
  logic                      r_dv;
  logic                      r_ferr;

  // Synchronizer resets to idle-high so reset release never looks like a start bit.
  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_d    (rx_i),
    .o_q    (w_rx_s)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_byte    <= 8'h00;
      r_dv      <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_dv   <= 1'b0;
      r_ferr <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
          if (!w_rx_s) r_state <= START;
        end

        // Mid-bit re-check rejects line glitches shorter than half a bit.
        START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt   <= '0;
            r_state <= w_rx_s ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // Sampling points stay at mid-bit because START ended at mid-bit.
        DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
            if (r_bit_idx == IDX_LAST) begin
              r_bit_idx <= '0;
              r_state   <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // The output byte only moves on a good stop bit, so the loader can
        // read it any time before the next frame completes.
        STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_dv    <= 1'b1;
              r_byte  <= r_shift;
              r_state <= IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= ERR_WAIT;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // Held-low line (break): wait for idle before looking for a start bit.
        ERR_WAIT: begin
          r_cnt <= '0;
          if (w_rx_s) r_state <= IDLE;
        end

        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rx_dv_o     = r_dv;
  assign frame_err_o = r_ferr;
  assign rx_byte_o   = r_byte;
  assign busy_o      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CPB8  = 8;
  localparam int HALF8 = (CPB8 - 1) / 2;
  localparam int CPB87 = 87;
  localparam int NRAND = 64;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic rx8 = 1'b1;
  logic rx87 = 1'b1;

  logic       dv8, ferr8, busy8;
  logic [7:0] byte8;
  logic       dv87, ferr87, busy87;
  logic [7:0] byte87;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         dv_cyc[$];
  logic [7:0] dv_byte[$];
  int         ferr_cyc[$];
  logic       busy_log[int];
  int         both8 = 0;

  logic [7:0] got87[$];
  logic [7:0] exp87[$];
  int         ferr87_n = 0;
  int         both87 = 0;

  uart_rx #(.CLKS_PER_BIT(CPB8)) dut8 (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .rx_i        (rx8),
    .rx_dv_o     (dv8),
    .rx_byte_o   (byte8),
    .frame_err_o (ferr8),
    .busy_o      (busy8)
  );

  uart_rx #(.CLKS_PER_BIT(CPB87)) dut87 (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .rx_i        (rx87),
    .rx_dv_o     (dv87),
    .rx_byte_o   (byte87),
    .frame_err_o (ferr87),
    .busy_o      (busy87)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation on the falling edge, away from the active edge.
  always @(negedge clk) begin
    busy_log[cyc] = busy8;
    if (dv8) begin
      dv_cyc.push_back(cyc);
      dv_byte.push_back(byte8);
    end
    if (ferr8) ferr_cyc.push_back(cyc);
    if (dv8 && ferr8) both8++;
    if (dv87) got87.push_back(byte87);
    if (ferr87) ferr87_n++;
    if (dv87 && ferr87) both87++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    dv_cyc.delete();
    dv_byte.delete();
    ferr_cyc.delete();
  endtask

  task automatic bit8(input logic v);
    rx8 = v;
    repeat (CPB8) @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] b, input logic stopv);
    bit8(1'b0);
    for (int i = 0; i < 8; i++) bit8(b[i]);
    bit8(stopv);
  endtask

  // One 8N1 frame on the 87-clock line with bit edges placed at the skewed
  // bit period (per-mille skew), rounded to whole clocks.
  task automatic send87(input logic [7:0] b, input int skew);
    int   prev;
    int   tend;
    logic v;
    prev = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      v = 1'b0;
      else if (i == 9) v = 1'b1;
      else             v = b[i-1];
      tend = (CPB87 * (1000 + skew) * (i + 1) + 500) / 1000;
      rx87 = v;
      repeat (tend - prev) @(posedge clk);
      #1;
      prev = tend;
    end
  endtask

  initial begin
    int p;
    int q;
    int lows;
    logic [7:0] seq[4];
    logic [7:0] rb;
    int sk;

    // Reset
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dv", dv8, 1'b0);
    check("rst_ferr", ferr8, 1'b0);
    check("rst_byte", byte8, 8'h00);
    check("rst_busy", busy8, 1'b0);
    check("rst_busy87", busy87, 1'b0);
    rst_ni = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_busy", busy8, 1'b0);

    // Clean frame 0x13 with exact timing
    clear_logs();
    p = cyc;
    send8(8'h13, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("f13_npulse", dv_cyc.size(), 1);
    if (dv_cyc.size() > 0) begin
      check("f13_cycle", dv_cyc[0], p + 4 + HALF8 + 9 * CPB8);
      check("f13_byte_at_dv", dv_byte[0], 8'h13);
    end
    check("f13_byte_hold", byte8, 8'h13);
    check("f13_nferr", ferr_cyc.size(), 0);
    check("f13_busy_before", busy_log[p + 2], 1'b0);
    check("f13_busy_first", busy_log[p + 3], 1'b1);
    check("f13_busy_last", busy_log[p + 78], 1'b1);
    check("f13_busy_after", busy_log[p + 79], 1'b0);
    lows = 0;
    for (int c = p + 3; c <= p + 78; c++) if (busy_log[c] !== 1'b1) lows++;
    check("f13_busy_span", lows, 0);

    // Two-cycle glitch
    clear_logs();
    p = cyc;
    rx8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx8 = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("glitch_ndv", dv_cyc.size(), 0);
    check("glitch_nferr", ferr_cyc.size(), 0);
    check("glitch_busy_seen", busy_log[p + 3], 1'b1);
    check("glitch_busy_gone", busy_log[p + 2 + HALF8 + 3], 1'b0);
    check("glitch_byte", byte8, 8'h13);

    // Frame 0xA5 with low stop bit and line held low afterwards
    clear_logs();
    p = cyc;
    send8(8'hA5, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    q = cyc;
    rx8 = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("ferr_npulse", ferr_cyc.size(), 1);
    if (ferr_cyc.size() > 0) check("ferr_cycle", ferr_cyc[0], p + 4 + HALF8 + 9 * CPB8);
    check("ferr_ndv", dv_cyc.size(), 0);
    check("ferr_byte_kept", byte8, 8'h13);
    check("ferr_busy_held", busy_log[q + 2], 1'b1);
    check("ferr_busy_release", busy_log[q + 3], 1'b0);

    // Back-to-back loader end word
    clear_logs();
    seq[0] = 8'hFF; seq[1] = 8'h0F; seq[2] = 8'h00; seq[3] = 8'h00;
    p = cyc;
    for (int i = 0; i < 4; i++) send8(seq[i], 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("b2b_npulse", dv_cyc.size(), 4);
    check("b2b_nferr", ferr_cyc.size(), 0);
    if (dv_cyc.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("b2b_byte%0d", i), dv_byte[i], seq[i]);
        check($sformatf("b2b_cycle%0d", i), dv_cyc[i], p + 79 + 80 * i);
      end
    end

    // Known byte before the reset test so the reset is visible on rx_byte_o
    clear_logs();
    send8(8'hC3, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_byte", byte8, 8'hC3);

    // Reset during bit 4
    bit8(1'b0);
    for (int i = 0; i < 4; i++) bit8(1'b1);
    rx8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_busy_before", busy8, 1'b1);
    rst_ni = 1'b0;
    #1;
    check("midrst_dv", dv8, 1'b0);
    check("midrst_ferr", ferr8, 1'b0);
    check("midrst_byte", byte8, 8'h00);
    check("midrst_busy", busy8, 1'b0);
    rx8 = 1'b1;
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("postrst_ndv", dv_cyc.size(), 0);
    check("postrst_nferr", ferr_cyc.size(), 0);
    send8(8'h5A, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("postrst_npulse", dv_cyc.size(), 1);
    check("postrst_byte", byte8, 8'h5A);
    check("no_overlap8", both8, 0);

    // Random stream at 87 clocks/bit with per-frame baud skew up to +-2%
    for (int i = 0; i < NRAND; i++) begin
      rb = 8'($urandom);
      sk = int'($urandom_range(40)) - 20;
      exp87.push_back(rb);
      send87(rb, sk);
      repeat ($urandom_range(30)) @(posedge clk);
      #1;
    end
    repeat (200) @(posedge clk);
    #1;
    check("rand_count", got87.size(), NRAND);
    check("rand_nferr", ferr87_n, 0);
    check("no_overlap87", both87, 0);
    for (int i = 0; i < NRAND; i++) begin
      if (i < got87.size()) check($sformatf("rand_byte%0d", i), got87[i], exp87[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
